// File: rtl/alu_pkg.sv
// Shared definitions for the ALU: op codes, FSM states, shifter modes.
package alu_pkg;

  localparam int OP_W = 4;

  localparam logic [OP_W-1:0] OP_ADD  = 4'd0;
  localparam logic [OP_W-1:0] OP_SUB  = 4'd1;
  localparam logic [OP_W-1:0] OP_AND  = 4'd2;
  localparam logic [OP_W-1:0] OP_OR   = 4'd3;
  localparam logic [OP_W-1:0] OP_SHR  = 4'd4;
  localparam logic [OP_W-1:0] OP_SHRA = 4'd5;
  localparam logic [OP_W-1:0] OP_SHL  = 4'd6;
  localparam logic [OP_W-1:0] OP_ROR  = 4'd7;
  localparam logic [OP_W-1:0] OP_ROL  = 4'd8;
  localparam logic [OP_W-1:0] OP_NEG  = 4'd9;
  localparam logic [OP_W-1:0] OP_NOT  = 4'd10;
  localparam logic [OP_W-1:0] OP_MUL  = 4'd11;
  localparam logic [OP_W-1:0] OP_DIV  = 4'd12;

  // Quotient reported for a divide by zero
  localparam logic [31:0] DIV_ZERO_Q = 32'hFFFFFFFF;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV
  } state_t;

  // Modes understood by the barrel shifter/rotator
  localparam logic [2:0] SR_SHR  = 3'd0;
  localparam logic [2:0] SR_SHRA = 3'd1;
  localparam logic [2:0] SR_SHL  = 3'd2;
  localparam logic [2:0] SR_ROR  = 3'd3;
  localparam logic [2:0] SR_ROL  = 3'd4;

  // Map an ALU op code onto a shifter mode (non-shift ops fall back to SHR,
  // their shifter output is never selected)
  function automatic logic [2:0] shift_mode(input logic [OP_W-1:0] code);
    case (code)
      OP_SHRA: return SR_SHRA;
      OP_SHL:  return SR_SHL;
      OP_ROR:  return SR_ROR;
      OP_ROL:  return SR_ROL;
      default: return SR_SHR;
    endcase
  endfunction

endpackage

// File: rtl/alu_shift_rot.sv
// Combinational 32-bit barrel shifter/rotator. Left operations are done by
// bit-reversing around a single right-shifting log stage network.
module alu_shift_rot
  import alu_pkg::*;
(
  input  logic [31:0] a,
  input  logic [4:0]  amt,
  input  logic [2:0]  mode,
  output logic [31:0] y
);

  logic        left;
  logic        rotate;
  logic        fill;
  logic [31:0] a_rev;
  logic [31:0] out_rev;
  logic [31:0] stage [0:5];

  assign left   = (mode == SR_SHL) || (mode == SR_ROL);
  assign rotate = (mode == SR_ROR) || (mode == SR_ROL);
  assign fill   = (mode == SR_SHRA) && a[31];

  genvar gi;

  generate
    for (gi = 0; gi < 32; gi++) begin : g_rev
      assign a_rev[gi]   = a[31-gi];
      assign out_rev[gi] = stage[5][31-gi];
    end
  endgenerate

  assign stage[0] = left ? a_rev : a;

  // Stage gi shifts right by 2^gi; vacated bits take wrapped bits or fill
  generate
    for (gi = 0; gi < 5; gi++) begin : g_stage
      localparam int SH = 1 << gi;
      logic [SH-1:0] top_bits;
      assign top_bits     = rotate ? stage[gi][SH-1:0] : {SH{fill}};
      assign stage[gi+1]  = amt[gi] ? {top_bits, stage[gi][31:SH]} : stage[gi];
    end
  endgenerate

  assign y = left ? out_rev : stage[5];

endmodule

// File: rtl/alu_unit.sv
// ALU between Y and ZHI/ZLOW. Single-cycle logic/arith ops, 32-step Booth
// multiply and 32-step restoring divide sharing one 33-bit adder/subtractor.
module alu_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] z_hi,
  output logic [WIDTH-1:0] z_lo,
  output logic             div_zero
);

  state_t      state_reg;
  logic [4:0]  cnt_reg;
  logic [32:0] acc_reg;       // Booth accumulator, or divide remainder in [31:0]
  logic [31:0] q_reg;         // Booth multiplier, or dividend/quotient shift reg
  logic [31:0] m_reg;         // multiplicand, or divisor magnitude
  logic        q1_reg;        // Booth extra low bit
  logic        a_neg_reg;     // remainder takes dividend sign
  logic        q_neg_reg;     // quotient negative
  logic        busy_reg;
  logic        done_reg;
  logic [31:0] z_hi_reg;
  logic [31:0] z_lo_reg;
  logic        div_zero_reg;

  logic [2:0]  sr_mode;
  logic [31:0] shift_res;
  logic [31:0] single_lo;
  logic [31:0] a_mag;
  logic [31:0] b_mag;

  logic [32:0] add_x;
  logic [32:0] add_y;
  logic        add_sub;
  logic [33:0] add_res;

  logic [32:0] mul_acc_next;
  logic [31:0] mul_q_next;
  logic        div_ok;
  logic [31:0] div_rem_next;
  logic [31:0] div_q_next;

  assign sr_mode = shift_mode(op);

  alu_shift_rot u_shift_rot (
    .a    (a),
    .amt  (b[4:0]),
    .mode (sr_mode),
    .y    (shift_res)
  );

  assign a_mag = a[31] ? (~a + 32'd1) : a;
  assign b_mag = b[31] ? (~b + 32'd1) : b;

  // Result of the ops that complete on the sampling edge
  always_comb begin
    single_lo = a + b;
    case (op)
      OP_SUB:  single_lo = a - b;
      OP_AND:  single_lo = a & b;
      OP_OR:   single_lo = a | b;
      OP_SHR, OP_SHRA, OP_SHL, OP_ROR, OP_ROL:
               single_lo = shift_res;
      OP_NEG:  single_lo = 32'd0 - a;
      OP_NOT:  single_lo = ~a;
      default: single_lo = a + b;
    endcase
  end

  // Operand selection for the shared adder/subtractor
  always_comb begin
    add_x   = acc_reg;
    add_y   = 33'd0;
    add_sub = 1'b0;
    if (state_reg == MUL) begin
      case ({q_reg[0], q1_reg})
        2'b01: add_y = {m_reg[31], m_reg};
        2'b10: begin
          add_y   = {m_reg[31], m_reg};
          add_sub = 1'b1;
        end
        default: add_y = 33'd0;
      endcase
    end else if (state_reg == DIV) begin
      add_x   = {acc_reg[31:0], q_reg[31]};
      add_y   = {1'b0, m_reg};
      add_sub = 1'b1;
    end
  end

  // Carry out of bit 32 means no borrow, i.e. the trial subtraction fits
  assign add_res = {1'b0, add_x} + {1'b0, add_y ^ {33{add_sub}}} + {33'd0, add_sub};

  assign mul_acc_next = {add_res[32], add_res[32:1]};
  assign mul_q_next   = {add_res[0], q_reg[31:1]};
  assign div_ok       = add_res[33];
  assign div_rem_next = div_ok ? add_res[31:0] : add_x[31:0];
  assign div_q_next   = {q_reg[30:0], div_ok};

  // Control FSM, iteration datapath and result registers
  always_ff @(posedge clk) begin
    if (clr) begin
      state_reg    <= IDLE;
      cnt_reg      <= 5'd0;
      acc_reg      <= 33'd0;
      q_reg        <= 32'd0;
      m_reg        <= 32'd0;
      q1_reg       <= 1'b0;
      a_neg_reg    <= 1'b0;
      q_neg_reg    <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      z_hi_reg     <= 32'd0;
      z_lo_reg     <= 32'd0;
      div_zero_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            div_zero_reg <= 1'b0;
            cnt_reg      <= 5'd0;
            if (op == OP_MUL) begin
              state_reg <= MUL;
              busy_reg  <= 1'b1;
              acc_reg   <= 33'd0;
              q_reg     <= b;
              m_reg     <= a;
              q1_reg    <= 1'b0;
            end else if (op == OP_DIV && b != 32'd0) begin
              state_reg <= DIV;
              busy_reg  <= 1'b1;
              acc_reg   <= 33'd0;
              q_reg     <= a_mag;
              m_reg     <= b_mag;
              a_neg_reg <= a[31];
              q_neg_reg <= a[31] ^ b[31];
            end else if (op == OP_DIV) begin
              z_lo_reg     <= DIV_ZERO_Q;
              z_hi_reg     <= a;
              div_zero_reg <= 1'b1;
              done_reg     <= 1'b1;
            end else begin
              z_lo_reg <= single_lo;
              z_hi_reg <= 32'd0;
              done_reg <= 1'b1;
            end
          end
        end
        MUL: begin
          acc_reg <= mul_acc_next;
          q_reg   <= mul_q_next;
          q1_reg  <= q_reg[0];
          cnt_reg <= cnt_reg + 5'd1;
          if (cnt_reg == 5'd31) begin
            z_hi_reg  <= mul_acc_next[31:0];
            z_lo_reg  <= mul_q_next;
            done_reg  <= 1'b1;
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end
        end
        DIV: begin
          acc_reg <= {1'b0, div_rem_next};
          q_reg   <= div_q_next;
          cnt_reg <= cnt_reg + 5'd1;
          if (cnt_reg == 5'd31) begin
            z_lo_reg  <= q_neg_reg ? (~div_q_next + 32'd1) : div_q_next;
            z_hi_reg  <= a_neg_reg ? (~div_rem_next + 32'd1) : div_rem_next;
            done_reg  <= 1'b1;
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy     = busy_reg;
  assign done     = done_reg;
  assign z_hi     = z_hi_reg;
  assign z_lo     = z_lo_reg;
  assign div_zero = div_zero_reg;

endmodule

// File: tb/tb_alu_unit.sv
// Bench for alu_unit: cycle-level reference model driven by the same inputs,
// directed literal cases, and a randomized phase with ignored starts and clr.
module tb_alu_unit;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    logic        it;
  } res_t;

  logic        clk;
  logic        clr;
  logic        start;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] z_hi;
  logic [31:0] z_lo;
  logic        div_zero;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 0;

  // Model state
  int          m_left = 0;
  logic [31:0] p_hi = 0, p_lo = 0;
  logic        exp_busy = 0, exp_done = 0, exp_dz = 0;
  logic [31:0] exp_hi = 0, exp_lo = 0;

  alu_unit #(.WIDTH(32)) dut (
    .clk      (clk),
    .clr      (clr),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .z_hi     (z_hi),
    .z_lo     (z_lo),
    .div_zero (div_zero)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, expv, $time);
    end
  endtask

  // Result of one operation computed straight from the arithmetic definition
  function automatic res_t model_calc(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    res_t        r;
    longint      sx, sy, p, qq, rr;
    int          sh;
    logic [63:0] dbl, tmp;
    r   = '0;
    sh  = int'(y[4:0]);
    dbl = {x, x};
    sx  = longint'($signed(x));
    sy  = longint'($signed(y));
    case (o)
      4'd1:  r.lo = x - y;
      4'd2:  r.lo = x & y;
      4'd3:  r.lo = x | y;
      4'd4:  r.lo = x >> sh;
      4'd5:  r.lo = $signed(x) >>> sh;
      4'd6:  r.lo = x << sh;
      4'd7:  begin tmp = dbl >> sh; r.lo = tmp[31:0]; end
      4'd8:  begin tmp = dbl << sh; r.lo = tmp[63:32]; end
      4'd9:  r.lo = 32'd0 - x;
      4'd10: r.lo = ~x;
      4'd11: begin
        p    = sx * sy;
        r.hi = p[63:32];
        r.lo = p[31:0];
        r.it = 1'b1;
      end
      4'd12: begin
        if (y == 32'd0) begin
          r.lo = 32'hFFFFFFFF;
          r.hi = x;
          r.dz = 1'b1;
        end else begin
          qq   = sx / sy;
          rr   = sx % sy;
          r.lo = qq[31:0];
          r.hi = rr[31:0];
          r.it = 1'b1;
        end
      end
      default: r.lo = x + y;
    endcase
    return r;
  endfunction

  // Cycle-level reference: countdown for iterating ops, immediate otherwise
  always @(posedge clk) begin : model
    res_t r;
    if (clr) begin
      m_left   <= 0;
      exp_busy <= 0;
      exp_done <= 0;
      exp_hi   <= 0;
      exp_lo   <= 0;
      exp_dz   <= 0;
    end else begin
      exp_done <= 0;
      if (m_left > 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          exp_done <= 1;
          exp_busy <= 0;
          exp_hi   <= p_hi;
          exp_lo   <= p_lo;
        end
      end else if (start) begin
        r = model_calc(op, a, b);
        exp_dz <= r.dz;
        if (r.it) begin
          m_left   <= 32;
          exp_busy <= 1;
          p_hi     <= r.hi;
          p_lo     <= r.lo;
        end else begin
          exp_done <= 1;
          exp_hi   <= r.hi;
          exp_lo   <= r.lo;
        end
      end
    end
  end

  // Every-cycle comparison against the model, on the falling edge
  always @(negedge clk) begin
    if (chk_en) begin
      check("done", {63'd0, done}, {63'd0, exp_done});
      check("busy", {63'd0, busy}, {63'd0, exp_busy});
      check("z_hi", {32'd0, z_hi}, {32'd0, exp_hi});
      check("z_lo", {32'd0, z_lo}, {32'd0, exp_lo});
      check("div_zero", {63'd0, div_zero}, {63'd0, exp_dz});
      if (done === 1'b1)
        $display("txn done: z_hi=%08h z_lo=%08h div_zero=%0b", z_hi, z_lo, div_zero);
    end
  end

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'h80000000;
      2:       return 32'hFFFFFFFF;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Issue one op, scramble inputs after sampling, wait for done and check
  task automatic do_op(input string nm, input logic [3:0] o, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] e_hi, input logic [31:0] e_lo,
                       input logic e_dz, input int e_lat);
    int cnt;
    cnt   = 0;
    op    = o;
    a     = x;
    b     = y;
    start = 1;
    do begin
      @(negedge clk);
      cnt++;
      start = 0;
      op    = 4'($urandom_range(0, 15));
      a     = $urandom;
      b     = $urandom;
    end while (done !== 1'b1 && cnt < 100);
    check({nm, "_latency"}, 64'(cnt), 64'(e_lat));
    check({nm, "_z_hi"}, {32'd0, z_hi}, {32'd0, e_hi});
    check({nm, "_z_lo"}, {32'd0, z_lo}, {32'd0, e_lo});
    check({nm, "_div_zero"}, {63'd0, div_zero}, {63'd0, e_dz});
  endtask

  initial begin : watchdog
    #500us;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    res_t r;
    int   cnt;
    int   ndone;

    clr = 1; start = 0; op = 0; a = 0; b = 0;

    // Model pinned by hand-computed values
    r = model_calc(4'd11, 32'hFFFFFFFD, 32'd7);
    check("model_mul_hi", {32'd0, r.hi}, 64'hFFFFFFFF);
    check("model_mul_lo", {32'd0, r.lo}, 64'hFFFFFFEB);
    r = model_calc(4'd12, 32'hFFFFFFEF, 32'd5);
    check("model_div_q", {32'd0, r.lo}, 64'hFFFFFFFD);
    check("model_div_r", {32'd0, r.hi}, 64'hFFFFFFFE);
    r = model_calc(4'd12, 32'h80000000, 32'hFFFFFFFF);
    check("model_div_ovf", {r.hi, r.lo}, 64'h0000000080000000);
    r = model_calc(4'd7, 32'd1, 32'd1);
    check("model_ror", {32'd0, r.lo}, 64'h80000000);
    r = model_calc(4'd8, 32'h80000001, 32'd4);
    check("model_rol", {32'd0, r.lo}, 64'h00000018);

    repeat (2) @(negedge clk);
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);
    check("reset_z", {z_hi, z_lo}, 64'd0);
    check("reset_div_zero", {63'd0, div_zero}, 64'd0);
    clr    = 0;
    chk_en = 1;

    // Directed cases with literal expectations
    do_op("add",     4'd0,  32'd5,        32'd7, 32'd0,        32'h0000000C, 1'b0, 1);
    do_op("shra",    4'd5,  32'h80000000, 32'd4, 32'd0,        32'hF8000000, 1'b0, 1);
    do_op("mul",     4'd11, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 33);
    do_op("div",     4'd12, 32'hFFFFFFEF, 32'd5, 32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0, 33);
    do_op("div_ovf", 4'd12, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 1'b0, 33);
    do_op("div0",    4'd12, 32'h12345678, 32'd0, 32'h12345678, 32'hFFFFFFFF, 1'b1, 1);
    do_op("add2",    4'd0,  32'd1,        32'd2, 32'd0,        32'd3,        1'b0, 1);
    do_op("neg",     4'd9,  32'd1,        32'd99, 32'd0,       32'hFFFFFFFF, 1'b0, 1);
    do_op("shl31",   4'd6,  32'd3,        32'd31, 32'd0,       32'h80000000, 1'b0, 1);

    // clr in the middle of a multiply
    op = 4'd11; a = 32'd9; b = 32'd9; start = 1;
    @(negedge clk);
    start = 0;
    repeat (9) @(negedge clk);
    clr = 1;
    @(negedge clk);
    clr = 0;
    check("clr_busy", {63'd0, busy}, 64'd0);
    check("clr_z", {z_hi, z_lo}, 64'd0);
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    check("clr_no_done", 64'(ndone), 64'd0);

    // Start during busy is ignored; start in the done cycle is accepted
    op = 4'd11; a = 32'd2; b = 32'd3; start = 1;
    @(negedge clk);
    start = 0;
    cnt   = 1;
    ndone = 0;
    repeat (5) begin @(negedge clk); cnt++; end
    op = 4'd0; a = 32'd100; b = 32'd100; start = 1;
    @(negedge clk);
    cnt++;
    start = 0;
    while (done !== 1'b1 && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    check("b2b_latency", 64'(cnt), 64'd33);
    check("b2b_mul_lo", {32'd0, z_lo}, 64'd6);
    op = 4'd7; a = 32'd1; b = 32'd1; start = 1;
    @(negedge clk);
    start = 0;
    check("b2b_ror_done", {63'd0, done}, 64'd1);
    check("b2b_ror_lo", {32'd0, z_lo}, 64'h80000000);

    // Randomized traffic, including starts while busy and occasional clr
    for (int i = 0; i < 3000; i++) begin
      start = ($urandom_range(0, 3) == 0);
      op    = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(11, 12)) : 4'($urandom_range(0, 15));
      a     = pick();
      b     = pick();
      clr   = ($urandom_range(0, 299) == 0);
      @(negedge clk);
    end
    start = 0;
    clr   = 0;
    repeat (40) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_unit.md
# alu_unit

Arithmetic/logic unit between the Y register and the ZHI/ZLOW register pair of the datapath. Operand A comes from Y_out and operand B from the shared bus. Single-cycle ops finish in one clock; signed multiply (radix-2 Booth) and signed divide (restoring) iterate over 32 clocks. Results are presented on z_hi/z_lo with a one-cycle done pulse, so the control sequencer can assert Z_in to latch them.

## Interface
- WIDTH, 32, operand width; only 32 is supported.
- clk  in  1  rising-edge clock, shared with the datapath.
- clr  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only when busy=0.
- op  in   4  operation code (alu_pkg), sampled with start.
- a  in  32  operand A (Y_out), sampled with start.
- b  in  32  operand B (bus), sampled with start.
- busy  out  1  high while MUL/DIV is iterating.
- done  out  1  one-cycle pulse; z_hi/z_lo valid in that cycle.
- z_hi  out  32  high word of the result.
- z_lo  out  32  low word of the result.
- div_zero  out  1  set with done when DIV had b=0; cleared at the next accepted start.

## Operation
- Op codes: ADD=0, SUB=1, AND=2, OR=3, SHR=4, SHRA=5, SHL=6, ROR=7, ROL=8, NEG=9, NOT=10, MUL=11, DIV=12. Codes 13-15 are treated as ADD.
- Single-cycle ops:
  - Result goes to z_lo; z_hi is 0.
  - Add/sub wrap modulo 2^32.
  - Shift and rotate amount is b[4:0]; SHRA sign-fills.
  - NEG = 0-a; NOT = ~a. Both ignore b.
- MUL: signed a×b as a 64-bit product; {z_hi,z_lo} = product.
- DIV: a is the dividend, b the divisor.
  - z_lo = quotient, truncated toward zero; z_hi = remainder, with the sign of the dividend.
  - The core works on magnitudes and corrects signs on the final iteration.
  - a=0x80000000, b=0xFFFFFFFF gives z_lo=0x80000000, z_hi=0.
- Divide by zero is detected at start and does not iterate. It finishes as a single-cycle op with z_lo=0xFFFFFFFF, z_hi=a, div_zero=1.
- FSM states: IDLE, MUL, DIV.
  - IDLE to MUL/DIV on start with op=MUL, or op=DIV with b≠0. The 5-bit iteration counter loads 0.
  - MUL/DIV to IDLE when the counter reaches 31: that edge writes the result and pulses done.
  - Every other accepted op stays in IDLE, writes the result and pulses done.
- start while busy=1 is ignored: no queueing and no effect on the current operation.
- z_hi, z_lo and div_zero hold their last values until the next completion. They do not change during iteration.

## Timing
- Reset values: busy=0, done=0, z_hi=0, z_lo=0, div_zero=0; FSM in IDLE, counter 0.
- Latency is counted from the edge that samples start to the edge after which done=1:
  - single-cycle ops and divide by zero: 1;
  - MUL and DIV: 33 (1 load + 32 iterations).
- busy goes to 1 after the load edge. It falls on the same edge that raises done.
- A new start may be given in the done cycle. It is accepted, which allows back-to-back ops.
- clr has priority over everything, including mid-iteration. After that edge all state is at reset values and the interrupted op never produces done.
- a, b and op may change freely after the sampling edge; operands are captured internally.

## Structure
- Package alu_pkg holds:
  - OP_W=4 and the op-code localparams above;
  - the FSM state enum (IDLE, MUL, DIV);
  - DIV_ZERO_Q=32'hFFFFFFFF.
- One sub-module: alu_shift_rot, a combinational barrel shifter/rotator that takes a, b[4:0] and a 3-bit mode, and produces a 32-bit result.
- The Booth and restoring iterations share one 33-bit adder/subtractor inside alu_unit.
- Target size is about 250 lines of RTL.

## Test plan
- ADD a=5, b=7 → done 1 cycle later; z_lo=0x0000000C, z_hi=0. Then SHRA a=0x80000000, b=4 → z_lo=0xF8000000.
- MUL a=0xFFFFFFFD (-3), b=7 → busy for 32 cycles, done at latency 33; z_hi=0xFFFFFFFF, z_lo=0xFFFFFFEB.
- DIV a=0xFFFFFFEF (-17), b=5 → done at latency 33; z_lo=0xFFFFFFFD (-3), z_hi=0xFFFFFFFE (-2), div_zero=0.
- DIV a=0x12345678, b=0 → done at latency 1; z_lo=0xFFFFFFFF, z_hi=0x12345678, div_zero=1. The next ADD clears div_zero.
- MUL started, then clr asserted 10 cycles in → busy=0, z_hi/z_lo=0 after that edge, and no done pulse in the following 40 cycles.
- MUL a=2, b=3, with a second start (op=ADD) pulsed mid-run → the ADD is ignored and only one done appears, with z_lo=6. A ROR a=1, b=1 issued in the done cycle is accepted → z_lo=0x80000000 one cycle later.
